mips_mc_controller: RTL

//  Multi-cycle control FSM that sequences the MIPS core datapath: fetch, decode, execute, memory and writeback.

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/mips_mc_controller_if.sv | 33 +++
 rtl/mips_main_decoder.sv | 26 ++
 rtl/mips_mc_controller.sv | 123 ++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, controller state and instruction-class types
// for the multi-cycle MIPS core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } ctrl_state_t;

  typedef enum logic [1:0] {
    AluAdd   = 2'd0,
    AluSub   = 2'd1,
    AluFunct = 2'd2
  } alu_op_t;

  // Exactly one bit set for any opcode/funct pair; nop covers unknown opcodes.
  typedef struct packed {
    logic rtype;
    logic jump;
    logic beq;
    logic addi;
    logic lw;
    logic sw;
    logic sys;
    logic nop;
  } inst_class_t;

endpackage

// File: rtl/mips_mc_controller_if.sv
// Controller <-> datapath signal bundle. master = controller, slave = datapath.
interface mips_mc_controller_if;
  import mips_pkg::*;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_imm;
  alu_op_t    alu_op;
  logic       mem_req;
  logic       mem_write_en;
  logic       halted;
  logic [2:0] state_o;

  modport master (
    input  opcode, funct, alu_zero,
    output ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg, alu_src_imm,
           alu_op, mem_req, mem_write_en, halted, state_o
  );

  modport slave (
    output opcode, funct, alu_zero,
    input  ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg, alu_src_imm,
           alu_op, mem_req, mem_write_en, halted, state_o
  );

endinterface

// File: rtl/mips_main_decoder.sv
// Combinational opcode/funct -> one-hot instruction class.
module mips_main_decoder
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output inst_class_t cls
);

  always_comb begin
    cls = '0;
    unique case (opcode)
      OP_RTYPE: begin
        if (funct == FN_SYSCALL) cls.sys = 1'b1;
        else                     cls.rtype = 1'b1;
      end
      OP_J:    cls.jump = 1'b1;
      OP_BEQ:  cls.beq  = 1'b1;
      OP_ADDI: cls.addi = 1'b1;
      OP_LW:   cls.lw   = 1'b1;
      OP_SW:   cls.sw   = 1'b1;
      default: cls.nop  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle control FSM: sequences fetch/decode/exec/mem/writeback and
// drives the datapath enables; halts stickily on SYSCALL.
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned CNT_W       = 4
) (
  input logic                  clk,
  input logic                  rst_b,
  mips_mc_controller_if.master bus
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MEM_LATENCY - 1);

  ctrl_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             halted_q;
  inst_class_t      cls;

  mips_main_decoder u_dec (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .cls    (cls)
  );

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q  <= StFetch;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        StFetch: state_q <= StDecode;
        StDecode: begin
          if (cls.jump || cls.nop) begin
            state_q <= StFetch;
          end else if (cls.sys) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else begin
            state_q <= StExec;
          end
        end
        StExec: begin
          if (cls.lw || cls.sw) begin
            state_q <= StMem;
            cnt_q   <= '0;
          end else if (cls.beq) begin
            state_q <= StFetch;
          end else begin
            state_q <= StWb;
          end
        end
        StMem: begin
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            state_q <= cls.lw ? StWb : StFetch;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWb:    state_q <= StFetch;
        StHalt:  state_q <= StHalt;
        default: state_q <= StFetch;
      endcase
    end
  end

  assign bus.state_o = state_q;
  assign bus.halted  = rst_b & halted_q;

  // Outputs are forced low while reset is held so an abandoned access cannot strobe.
  always_comb begin
    bus.ir_write     = 1'b0;
    bus.pc_write     = 1'b0;
    bus.pc_src       = 2'd0;
    bus.reg_write    = 1'b0;
    bus.reg_dst      = 1'b0;
    bus.mem_to_reg   = 1'b0;
    bus.alu_src_imm  = 1'b0;
    bus.alu_op       = AluAdd;
    bus.mem_req      = 1'b0;
    bus.mem_write_en = 1'b0;
    if (rst_b) begin
      unique case (state_q)
        StFetch: bus.ir_write = 1'b1;
        StDecode: begin
          if (cls.jump) begin
            bus.pc_write = 1'b1;
            bus.pc_src   = 2'd2;
          end else if (cls.nop) begin
            bus.pc_write = 1'b1;
          end
        end
        StExec: begin
          if (cls.rtype) bus.alu_op = AluFunct;
          if (cls.addi || cls.lw || cls.sw) bus.alu_src_imm = 1'b1;
          if (cls.beq) begin
            bus.alu_op   = AluSub;
            bus.pc_write = 1'b1;
            bus.pc_src   = {1'b0, bus.alu_zero};
          end
        end
        StMem: begin
          bus.mem_req = 1'b1;
          if (cls.sw && cnt_q == CntLast) begin
            bus.mem_write_en = 1'b1;
            bus.pc_write     = 1'b1;
          end
        end
        StWb: begin
          bus.reg_write  = 1'b1;
          bus.pc_write   = 1'b1;
          bus.reg_dst    = cls.rtype;
          bus.mem_to_reg = cls.lw;
        end
        default: ;
      endcase
    end
  end

endmodule
